// File: rtl/common.sv
// Shared scalar widths used across the decode/execute pipeline.
// u32 carries raw instructions, u64 is the widest datapath word.
package common;

    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

endpackage

// File: rtl/pipes.sv
// Pipeline-level types: immediate formats, skid buffer states and
// a sign-extension helper shared by the immediate generator.
package pipes;

    import common::*;

    typedef enum logic [3:0] {
        IMM_NONE = 4'd0,
        IMM_I    = 4'd1,
        IMM_S    = 4'd2,
        IMM_B    = 4'd3,
        IMM_U    = 4'd4,
        IMM_J    = 4'd5,
        IMM_Z    = 4'd6,
        IMM_CI   = 4'd7,
        IMM_CJ   = 4'd8,
        IMM_CB   = 4'd9
    } imm_fmt_t;

    // Encoding is (out_valid, skid_valid).
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b10,
        BUF_FULL  = 2'b11
    } buf_state_t;

    // Sign-extend the low w bits of v to 64 bits.
    function automatic u64 sext(input u64 v, input int unsigned w);
        int unsigned sh;
        sh = 64 - w;
        return u64'($signed(v << sh) >>> sh);
    endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction for all base and compressed formats.
// Ports: fmt/instr in; imm (XLEN, extended) and err (illegal format) out.
module imm_extract
    import common::*;
    import pipes::*;
#(
    parameter int XLEN   = 64,
    parameter bit RVC_EN = 1'b1
) (
    input  imm_fmt_t        fmt,
    input  u32              instr,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    u64   wide;
    logic unused_bits;

    always_comb begin
        wide = '0;
        err  = 1'b0;
        unique case (fmt)
            IMM_NONE: wide = '0;
            IMM_I: wide = sext(u64'(instr[31:20]), 12);
            IMM_S: wide = sext(u64'({instr[31:25], instr[11:7]}), 12);
            IMM_B: wide = sext(u64'({instr[31], instr[7], instr[30:25],
                                     instr[11:8], 1'b0}), 13);
            IMM_U: wide = sext(u64'({instr[31:12], 12'b0}), 32);
            IMM_J: wide = sext(u64'({instr[31], instr[19:12], instr[20],
                                     instr[30:21], 1'b0}), 21);
            IMM_Z: wide = u64'(instr[19:15]);
            IMM_CI: begin
                if (RVC_EN) wide = sext(u64'({instr[12], instr[6:2]}), 6);
                else        err  = 1'b1;
            end
            IMM_CJ: begin
                if (RVC_EN)
                    wide = sext(u64'({instr[12], instr[8], instr[10:9],
                                      instr[6], instr[7], instr[2],
                                      instr[11], instr[5:3], 1'b0}), 12);
                else
                    err = 1'b1;
            end
            IMM_CB: begin
                if (RVC_EN)
                    wide = sext(u64'({instr[12], instr[6:5], instr[2],
                                      instr[11:10], instr[4:3], 1'b0}), 9);
                else
                    err = 1'b1;
            end
            default: err = 1'b1;
        endcase
    end

    assign imm = wide[XLEN-1:0];

    // Opcode quadrant bits and, for RV32, the upper half are not needed.
    assign unused_bits = ^{instr[1:0], wide};

endmodule

// File: rtl/immgen_stage.sv
// Registered immediate/target generation stage with a two-entry skid buffer.
// Ports: in_* beat (valid/ready, fmt, instr, pc), out_* beat (imm, target, pc, err).
module immgen_stage
    import common::*;
    import pipes::*;
#(
    parameter int XLEN   = 64,
    parameter bit RVC_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  imm_fmt_t        in_fmt,
    input  u32              in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_pc,
    output logic            out_err
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] tgt;
        logic [XLEN-1:0] pc;
        logic            err;
    } beat_t;

    buf_state_t state_q, state_d;
    beat_t      out_q, out_d;
    beat_t      skid_q, skid_d;
    beat_t      new_beat;
    logic       accept;
    logic       drain;

    // Payload is computed before buffering so both slots hold final values.
    imm_extract #(
        .XLEN   (XLEN),
        .RVC_EN (RVC_EN)
    ) u_extract (
        .fmt   (in_fmt),
        .instr (in_instr),
        .imm   (new_beat.imm),
        .err   (new_beat.err)
    );

    assign new_beat.pc  = in_pc;
    assign new_beat.tgt = in_pc + new_beat.imm;

    assign accept = in_valid & (state_q != BUF_FULL);
    assign drain  = (state_q != BUF_EMPTY) & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BUF_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = BUF_EMPTY;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (accept) begin
                        state_d = BUF_ONE;
                        out_d   = new_beat;
                    end
                end
                BUF_ONE: begin
                    if (accept && drain) begin
                        out_d = new_beat;
                    end else if (accept) begin
                        state_d = BUF_FULL;
                        skid_d  = new_beat;
                    end else if (drain) begin
                        state_d = BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (drain) begin
                        state_d = BUF_ONE;
                        out_d   = skid_q;
                    end
                end
                default: state_d = BUF_EMPTY;
            endcase
        end
    end

    // Handshake outputs depend only on the state register.
    always_comb begin
        out_valid  = (state_q != BUF_EMPTY);
        in_ready   = (state_q != BUF_FULL);
        out_imm    = out_q.imm;
        out_target = out_q.tgt;
        out_pc     = out_q.pc;
        out_err    = out_q.err;
    end

endmodule

// File: tb/tb_immgen_stage.sv
// Self-checking bench for immgen_stage: RV64+RVC and RV32 without RVC
// instances share one stimulus stream and one queue-level reference model.
module tb_immgen_stage;

    import common::*;
    import pipes::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    imm_fmt_t    in_fmt;
    u32          in_instr;
    logic [63:0] in_pc;

    logic        rdy64, ov64, err64;
    logic [63:0] imm64, tgt64, pc64;
    logic        rdy32, ov32, err32;
    logic [31:0] imm32, tgt32, pc32;

    immgen_stage #(.XLEN(64), .RVC_EN(1'b1)) dut64 (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (rdy64),
        .in_fmt     (in_fmt),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .out_valid  (ov64),
        .out_ready  (out_ready),
        .out_imm    (imm64),
        .out_target (tgt64),
        .out_pc     (pc64),
        .out_err    (err64)
    );

    immgen_stage #(.XLEN(32), .RVC_EN(1'b0)) dut32 (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (rdy32),
        .in_fmt     (in_fmt),
        .in_instr   (in_instr),
        .in_pc      (in_pc[31:0]),
        .out_valid  (ov32),
        .out_ready  (out_ready),
        .out_imm    (imm32),
        .out_target (tgt32),
        .out_pc     (pc32),
        .out_err    (err32)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] imm64, tgt64, pc64;
        logic        err64;
        logic [31:0] imm32, tgt32, pc32;
        logic        err32;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;

    function automatic longint sx(input longint v, input int w);
        if (v >= (longint'(1) << (w - 1))) return v - (longint'(1) << w);
        return v;
    endfunction

    function automatic longint fld(input u32 i, input int lo, input int w);
        return longint'((i >> lo) & ((32'd1 << w) - 32'd1));
    endfunction

    // Immediate value from the format rules, built as a weighted sum of fields.
    function automatic exp_t model(input imm_fmt_t f, input u32 i,
                                   input logic [63:0] pc);
        exp_t   e;
        longint v = 0;
        bit     bad = 0;
        bit     rvc = 0;
        case (f)
            IMM_NONE: v = 0;
            IMM_I: v = sx(fld(i, 20, 12), 12);
            IMM_S: v = sx(fld(i, 25, 7) * 32 + fld(i, 7, 5), 12);
            IMM_B: v = sx(fld(i, 31, 1) * 4096 + fld(i, 7, 1) * 2048
                          + fld(i, 25, 6) * 32 + fld(i, 8, 4) * 2, 13);
            IMM_U: v = sx(fld(i, 12, 20) * 4096, 32);
            IMM_J: v = sx(fld(i, 31, 1) * 1048576 + fld(i, 12, 8) * 4096
                          + fld(i, 20, 1) * 2048 + fld(i, 21, 10) * 2, 21);
            IMM_Z: v = fld(i, 15, 5);
            IMM_CI: begin
                rvc = 1;
                v = sx(fld(i, 12, 1) * 32 + fld(i, 2, 5), 6);
            end
            IMM_CJ: begin
                rvc = 1;
                v = sx(fld(i, 12, 1) * 2048 + fld(i, 8, 1) * 1024
                       + fld(i, 9, 2) * 256 + fld(i, 6, 1) * 128
                       + fld(i, 7, 1) * 64 + fld(i, 2, 1) * 32
                       + fld(i, 11, 1) * 16 + fld(i, 3, 3) * 2, 12);
            end
            IMM_CB: begin
                rvc = 1;
                v = sx(fld(i, 12, 1) * 256 + fld(i, 5, 2) * 64
                       + fld(i, 2, 1) * 32 + fld(i, 10, 2) * 8
                       + fld(i, 3, 2) * 2, 9);
            end
            default: bad = 1;
        endcase
        e.imm64 = bad ? 64'd0 : v;
        e.tgt64 = pc + e.imm64;
        e.pc64  = pc;
        e.err64 = bad;
        e.imm32 = (bad || rvc) ? 32'd0 : v[31:0];
        e.tgt32 = pc[31:0] + e.imm32;
        e.pc32  = pc[31:0];
        e.err32 = bad || rvc;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic check_outs();
        chk("out_valid64", 64'(ov64), 64'(q.size() > 0));
        chk("in_ready64", 64'(rdy64), 64'(q.size() < 2));
        chk("out_valid32", 64'(ov32), 64'(q.size() > 0));
        chk("in_ready32", 64'(rdy32), 64'(q.size() < 2));
        if (q.size() > 0) begin
            chk("imm64", imm64, q[0].imm64);
            chk("tgt64", tgt64, q[0].tgt64);
            chk("pc64", pc64, q[0].pc64);
            chk("err64", 64'(err64), 64'(q[0].err64));
            chk("imm32", 64'(imm32), 64'(q[0].imm32));
            chk("tgt32", 64'(tgt32), 64'(q[0].tgt32));
            chk("pc32", 64'(pc32), 64'(q[0].pc32));
            chk("err32", 64'(err32), 64'(q[0].err32));
        end
    endtask

    task automatic check_zero();
        chk("rst ov64", 64'(ov64), 64'd0);
        chk("rst rdy64", 64'(rdy64), 64'd1);
        chk("rst imm64", imm64, 64'd0);
        chk("rst tgt64", tgt64, 64'd0);
        chk("rst pc64", pc64, 64'd0);
        chk("rst err64", 64'(err64), 64'd0);
        chk("rst ov32", 64'(ov32), 64'd0);
        chk("rst rdy32", 64'(rdy32), 64'd1);
        chk("rst imm32", 64'(imm32), 64'd0);
        chk("rst tgt32", 64'(tgt32), 64'd0);
        chk("rst pc32", 64'(pc32), 64'd0);
        chk("rst err32", 64'(err32), 64'd0);
    endtask

    // One clock: drive at negedge, advance the model at posedge, check at negedge.
    task automatic cyc(input bit v, input imm_fmt_t f, input u32 i,
                       input logic [63:0] pc, input bit rdy, input bit fl);
        bit acc;
        bit drn;
        in_valid  = v;
        in_fmt    = f;
        in_instr  = i;
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
        acc = v && !fl && (q.size() < 2);
        drn = (q.size() > 0) && rdy;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(model(f, i, pc));
        end
        @(negedge clk);
        check_outs();
    endtask

    initial begin
        int sent;
        int drained;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_fmt    = IMM_NONE;
        in_instr  = '0;
        in_pc     = '0;
        repeat (2) @(negedge clk);
        check_zero();
        reset = 1'b0;

        cyc(1, IMM_I, 32'hFFF00093, 64'h1000, 1, 0);
        chk("I imm", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("I tgt", tgt64, 64'h0000_0000_0000_0FFF);

        cyc(1, IMM_J, 32'h8000006F, 64'h0010_0000, 1, 0);
        chk("J imm32", 64'(imm32), 64'hFFF0_0000);
        chk("J tgt32", 64'(tgt32), 64'h0);

        cyc(1, IMM_CJ, 32'h0000_A001, 64'h3000, 1, 0);
        chk("CJ err32", 64'(err32), 64'd1);
        chk("CJ imm32", 64'(imm32), 64'd0);
        chk("CJ tgt32", 64'(tgt32), 64'h3000);

        cyc(1, IMM_CB, 32'h0000_D001, 64'h4000, 1, 0);
        chk("CB imm64", imm64, 64'hFFFF_FFFF_FFFF_FF00);
        cyc(0, IMM_NONE, 32'h0, 64'h0, 1, 0);

        for (int k = 0; k < 80; k++) begin
            cyc($urandom_range(0, 3) != 0,
                imm_fmt_t'(4'($urandom_range(0, 15))),
                $urandom, {$urandom, $urandom},
                $urandom_range(0, 2) != 0,
                $urandom_range(0, 15) == 0);
        end
        repeat (3) cyc(0, IMM_NONE, 32'h0, 64'h0, 1, 0);

        sent    = 0;
        drained = 0;
        for (int k = 0; k < 10; k++) begin
            bit rdy;
            bit v;
            rdy = !(k == 1 || k == 2);
            v   = sent < 4;
            if (rdy && ov64) begin
                chk("bp order", pc64, 64'h2000 + 64'(4 * drained));
                drained++;
            end
            if (v && q.size() < 2) begin
                cyc(1, IMM_S, $urandom, 64'h2000 + 64'(4 * sent), rdy, 0);
                sent++;
            end else begin
                cyc(v, IMM_S, $urandom, 64'h2000 + 64'(4 * sent), rdy, 0);
            end
            if (k == 1) chk("bp full rdy", 64'(rdy64), 64'd0);
        end
        chk("bp drained", 64'(drained), 64'd4);

        cyc(1, IMM_I, $urandom, 64'h5000, 0, 0);
        cyc(1, IMM_I, $urandom, 64'h5004, 0, 0);
        chk("full rdy", 64'(rdy64), 64'd0);
        cyc(1, IMM_U, $urandom, 64'h5008, 0, 1);
        chk("flush ov", 64'(ov64), 64'd0);
        chk("flush rdy", 64'(rdy64), 64'd1);
        repeat (2) cyc(0, IMM_NONE, 32'h0, 64'h0, 1, 0);

        cyc(1, IMM_B, $urandom, 64'h6000, 0, 0);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1 q.delete();
        check_zero();
        #1 reset = 1'b0;
        cyc(1, IMM_S, 32'hFE00_0FA3, 64'h7000, 1, 0);
        chk("post rst ov", 64'(ov64), 64'd1);
        chk("post rst tgt", tgt64, 64'h6FFF);
        cyc(0, IMM_NONE, 32'h0, 64'h0, 1, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
